cram_backup_arb: RTL

CRAM_BACKUP_ARB -- requirements
Module: cram_backup_arb

---
 rtl/cram_backup_arb_if.sv | 43 ++++
 rtl/cram_backup_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cram_backup_arb_if.sv
// Bundles the CPU, SD-buffer and shared cart-RAM port signals of cram_backup_arb.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface cram_backup_arb_if;
  logic        ce_cpu;
  logic [3:0]  ram_mask;
  logic        save_req;
  logic        load_req;
  logic [16:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;

  logic [8:0]  sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;

  logic        busy;
  logic        dirty;
  logic        overflow;

  modport slave (
    input  ce_cpu, ram_mask, save_req, load_req, cpu_addr, cpu_wr, cpu_di,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, ram_q,
    output sd_lba, sd_rd, sd_wr, sd_buff_din, ram_addr, ram_we, ram_d,
    output busy, dirty, overflow
  );

  modport master (
    output ce_cpu, ram_mask, save_req, load_req, cpu_addr, cpu_wr, cpu_di,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, ram_q,
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, ram_addr, ram_we, ram_d,
    input  busy, dirty, overflow
  );
endinterface

// File: rtl/cram_backup_arb.sv
// Cart-RAM backup arbiter: streams the RAM image to/from SD sector by sector while
// sharing the single RAM port with CPU writes through a one-entry deferral buffer.
module cram_backup_arb (
  input  logic              clk_sys,
  input  logic              reset,
  cram_backup_arb_if.slave  bus
);

  localparam int unsigned LbaW  = 8;
  localparam int unsigned AddrW = 17;
  localparam int unsigned DataW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    NEXT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               save_q, save_d;
  logic [LbaW-1:0]    lba_q, lba_d;
  logic               sd_rd_q, sd_rd_d;
  logic               sd_wr_q, sd_wr_d;
  logic               busy_q, busy_d;
  logic               dirty_q, dirty_d;
  logic               overflow_q, overflow_d;
  logic               pend_vld_q, pend_vld_d;
  logic [AddrW-1:0]   pend_addr_q, pend_addr_d;
  logic [DataW-1:0]   pend_data_q, pend_data_d;

  logic               clr_dirty_c;
  logic               cpu_commit_c;
  logic               cpu_wr_c;
  logic [AddrW-1:0]   ram_addr_c;
  logic               ram_we_c;
  logic [DataW-1:0]   ram_d_c;

  // State and control registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      save_q      <= 1'b0;
      lba_q       <= '0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      dirty_q     <= 1'b0;
      overflow_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      save_q      <= save_d;
      lba_q       <= lba_d;
      sd_rd_q     <= sd_rd_d;
      sd_wr_q     <= sd_wr_d;
      busy_q      <= busy_d;
      dirty_q     <= dirty_d;
      overflow_q  <= overflow_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  // Sector sequencing FSM
  always_comb begin
    state_d     = state_q;
    save_d      = save_q;
    lba_d       = lba_q;
    clr_dirty_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.save_req) begin
          state_d = REQ;
          save_d  = 1'b1;
          lba_d   = '0;
        end else if (bus.load_req) begin
          state_d = REQ;
          save_d  = 1'b0;
          lba_d   = '0;
        end
      end
      REQ: begin
        if (bus.sd_ack) state_d = XFER;
      end
      XFER: begin
        if (!bus.sd_ack) state_d = NEXT;
      end
      NEXT: begin
        if (lba_q == {bus.ram_mask, 4'hF}) begin
          state_d     = IDLE;
          clr_dirty_c = 1'b1;
        end else begin
          state_d = REQ;
          lba_d   = lba_q + LbaW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    sd_wr_d = (state_d == REQ) &&  save_d;
    sd_rd_d = (state_d == REQ) && !save_d;
    busy_d  = (state_d != IDLE);
  end

  // RAM port ownership, deferred CPU writes and status flags
  always_comb begin
    cpu_wr_c     = bus.ce_cpu & bus.cpu_wr;
    pend_vld_d   = pend_vld_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    overflow_d   = overflow_q;
    cpu_commit_c = 1'b0;
    ram_addr_c   = bus.cpu_addr;
    ram_d_c      = bus.cpu_di;
    ram_we_c     = 1'b0;

    if (state_q == XFER) begin
      ram_addr_c = {lba_q, bus.sd_buff_addr};
      ram_d_c    = bus.sd_buff_dout;
      ram_we_c   = !save_q && bus.sd_buff_wr;
      if (cpu_wr_c) begin
        if (!pend_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = bus.cpu_addr;
          pend_data_d = bus.cpu_di;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end else if (pend_vld_q) begin
      // Drain cycle: the older write goes out, a new one takes its slot
      ram_addr_c   = pend_addr_q;
      ram_d_c      = pend_data_q;
      ram_we_c     = 1'b1;
      cpu_commit_c = 1'b1;
      pend_vld_d   = cpu_wr_c;
      if (cpu_wr_c) begin
        pend_addr_d = bus.cpu_addr;
        pend_data_d = bus.cpu_di;
      end
    end else if (cpu_wr_c) begin
      ram_we_c     = 1'b1;
      cpu_commit_c = 1'b1;
    end

    if (cpu_commit_c)     dirty_d = 1'b1;
    else if (clr_dirty_c) dirty_d = 1'b0;
    else                  dirty_d = dirty_q;
  end

  assign bus.sd_lba      = {1'b0, lba_q};
  assign bus.sd_rd       = sd_rd_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.sd_buff_din = bus.ram_q;
  assign bus.ram_addr    = ram_addr_c;
  assign bus.ram_we      = ram_we_c & ~reset;
  assign bus.ram_d       = ram_d_c;
  assign bus.busy        = busy_q;
  assign bus.dirty       = dirty_q;
  assign bus.overflow    = overflow_q;

endmodule
